// File: rtl/row_op_sequencer.sv
// row_op_sequencer
//
// Command-driven controller for a bank of ROWS register rows. Each accepted
// command reads a source row over the up bus, captures the word, then writes
// it into the destination row through the row's adder/logic path
// (dst <= dst OP src) and returns the destination overflow as a response.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cmd_*                valid/ready command port (op, src, dst, carry-in)
//   resp_*               valid/ready response port (overflow, error)
//   rd_sel_up/dn         one-hot row read selects (dn tied 0)
//   wr_sel_up/dn, wr_en  one-hot row write selects / enables (dn tied 0)
//   op_fa                one-hot row function: bit0 sum, bit1 and, bit2 xor, bit3 or
//   first_carry          carry into column 0 of every row
//   rd_bus_up            word returned by the selected row
//   wr_bus_up            word driven to the rows during execute
//   ovf_in               per-row carry-out
//
// Build option
//   ROW_SEQ_SUB_EN       when defined, op 100 (dst <= dst - src) is legal;
//                        otherwise it is rejected with resp_err.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// READ  | source row driven onto up bus, word captured at end of cycle
// EXEC  | destination row written through its adder/logic path
// RESP  | response held until resp_ready

module row_op_sequencer #(
    parameter int N    = 32,
    parameter int ROWS = 16,
    parameter int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [IDXW-1:0] cmd_src,
    input  logic [IDXW-1:0] cmd_dst,
    input  logic            cmd_cin,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_ovf,
    output logic            resp_err,
    output logic [ROWS-1:0] rd_sel_up,
    output logic [ROWS-1:0] rd_sel_dn,
    output logic [ROWS-1:0] wr_sel_up,
    output logic [ROWS-1:0] wr_sel_dn,
    output logic [ROWS-1:0] wr_en,
    output logic [3:0]      op_fa,
    output logic            first_carry,
    input  logic [N-1:0]    rd_bus_up,
    output logic [N-1:0]    wr_bus_up,
    input  logic [ROWS-1:0] ovf_in
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    state_t          state, state_next;
    logic [2:0]      op_q;
    logic [IDXW-1:0] src_q, dst_q;
    logic            cin_q;
    logic [N-1:0]    data_q;
    logic            ovf_q, err_q;
    logic            cmd_legal;
    logic            op_arith;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef ROW_SEQ_SUB_EN
        return op <= OP_SUB;
`else
        return op <= OP_OR;
`endif
    endfunction

    // Index range matters when ROWS is not a power of two.
    assign cmd_legal = op_legal(cmd_op) &&
                       (int'(cmd_src) < ROWS) && (int'(cmd_dst) < ROWS);

    // Logic ops never report overflow, whatever the row's carry chain says.
    assign op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    assign rd_sel_dn = '0;
    assign wr_sel_dn = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            cin_q  <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
                        cin_q <= cmd_cin;
                        err_q <= !cmd_legal;
                        ovf_q <= 1'b0;
                    end
                end
                READ: data_q <= rd_bus_up;
                EXEC: ovf_q  <= op_arith & ovf_in[dst_q];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_ovf    = 1'b0;
        resp_err    = 1'b0;
        rd_sel_up   = '0;
        wr_sel_up   = '0;
        wr_en       = '0;
        op_fa       = 4'b0000;
        first_carry = 1'b0;
        wr_bus_up   = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = cmd_legal ? READ : RESP;
                end
            end
            READ: begin
                rd_sel_up  = ROW_ONE << src_q;
                state_next = EXEC;
            end
            EXEC: begin
                wr_sel_up = ROW_ONE << dst_q;
                wr_en     = ROW_ONE << dst_q;
                wr_bus_up = data_q;
                case (op_q)
                    OP_ADD: begin
                        op_fa       = 4'b0001;
                        first_carry = cin_q;
                    end
                    OP_AND: op_fa = 4'b0010;
                    OP_XOR: op_fa = 4'b0100;
                    OP_OR:  op_fa = 4'b1000;
`ifdef ROW_SEQ_SUB_EN
                    // Two's-complement subtract through the row adder.
                    OP_SUB: begin
                        op_fa       = 4'b0001;
                        first_carry = 1'b1;
                        wr_bus_up   = ~data_q;
                    end
`endif
                    default: ;
                endcase
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_ovf   = ovf_q;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_row_op_sequencer.sv
// Testbench for row_op_sequencer with a behavioural row bank (ROWS=12).
// Expected responses are queued at issue time and checked by a monitor.

module tb_row_op_sequencer;

    localparam int N    = 32;
    localparam int ROWS = 12;
    localparam int IDXW = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    logic            clk;
    logic            rst;
    logic            cmd_valid, cmd_ready;
    logic [2:0]      cmd_op;
    logic [IDXW-1:0] cmd_src, cmd_dst;
    logic            cmd_cin;
    logic            resp_valid, resp_ready, resp_ovf, resp_err;
    logic [ROWS-1:0] rd_sel_up, rd_sel_dn, wr_sel_up, wr_sel_dn, wr_en;
    logic [3:0]      op_fa;
    logic            first_carry;
    logic [N-1:0]    rd_bus_up, wr_bus_up;
    logic [ROWS-1:0] ovf_in;

    row_op_sequencer #(.N(N), .ROWS(ROWS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_cin(cmd_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ovf(resp_ovf), .resp_err(resp_err),
        .rd_sel_up(rd_sel_up), .rd_sel_dn(rd_sel_dn),
        .wr_sel_up(wr_sel_up), .wr_sel_dn(wr_sel_dn), .wr_en(wr_en),
        .op_fa(op_fa), .first_carry(first_carry),
        .rd_bus_up(rd_bus_up), .wr_bus_up(wr_bus_up), .ovf_in(ovf_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural row bank ----------------
    logic [N-1:0]    rows [0:ROWS-1];
    logic            load_en;
    logic [IDXW-1:0] load_idx;
    logic [N-1:0]    load_val;

    function automatic logic carry_out(input logic [N-1:0] a, b, input logic c);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        return s[N];
    endfunction

    function automatic logic [N-1:0] row_result(input logic [N-1:0] r, b,
                                                input logic c, input logic [3:0] f);
        case (f)
            4'b0001: return r + b + {{(N-1){1'b0}}, c};
            4'b0010: return r & b;
            4'b0100: return r ^ b;
            4'b1000: return r | b;
            default: return r;
        endcase
    endfunction

    always_comb begin
        rd_bus_up = '0;
        ovf_in    = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rd_sel_up[i]) rd_bus_up = rd_bus_up | rows[i];
            ovf_in[i] = op_fa[0] & carry_out(rows[i], wr_bus_up, first_carry);
        end
    end

    always @(posedge clk) begin
        if (load_en) rows[load_idx] <= load_val;
        for (int i = 0; i < ROWS; i++) begin
            if (wr_en[i]) rows[i] <= row_result(rows[i], wr_bus_up, first_carry, op_fa);
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event did not occur", name);
    endtask

    typedef struct {
        logic        err;
        logic        ovf;
        logic        chk_row;
        int          row;
        logic [N-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic quiet;

    task automatic expect_resp(input logic err, input logic ovf, input logic chk,
                               input int row, input logic [N-1:0] val);
        exp_t e;
        e.err = err; e.ovf = ovf; e.chk_row = chk; e.row = row; e.val = val;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ctl_onehot",
                  {63'd0, (!$onehot0(rd_sel_up) || !$onehot0(wr_sel_up) ||
                           (wr_en != wr_sel_up) || (|rd_sel_dn) || (|wr_sel_dn))}, 64'd0);
            if (quiet)
                check("quiet_ctl", {63'd0, |{rd_sel_up, wr_sel_up, wr_en, op_fa, first_carry}}, 64'd0);
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("sb_expected_entry");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_err", {63'd0, resp_err}, {63'd0, mon_e.err});
                    check("resp_ovf", {63'd0, resp_ovf}, {63'd0, mon_e.ovf});
                    if (mon_e.chk_row)
                        check("row_val", {32'd0, rows[mon_e.row]}, {32'd0, mon_e.val});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [IDXW-1:0] idx, input logic [N-1:0] val);
        @(posedge clk); #1;
        load_en = 1'b1; load_idx = idx; load_val = val;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Returns one time unit after the accepting edge (cycle k+1).
    task automatic issue(input logic [2:0] op, input logic [IDXW-1:0] src,
                         input logic [IDXW-1:0] dst, input logic cin);
        logic got;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_cin = cin;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("cmd_accept_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("idle_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
        cmd_cin = 1'b0; resp_ready = 1'b1; load_en = 1'b0; load_idx = '0;
        load_val = '0; quiet = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_ctl", {35'd0, rd_sel_up, wr_en, op_fa, first_carry}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Add: row7 = 10 + 5
        load(3, 32'd5);
        load(7, 32'd10);
        expect_resp(1'b0, 1'b0, 1'b1, 7, 32'd15);
        issue(OP_ADD, 3, 7, 1'b0);
        @(negedge clk);
        check("add_read_sel", {52'd0, rd_sel_up}, 64'h008);
        check("add_read_noen", {52'd0, wr_en}, 64'd0);
        @(negedge clk);
        check("add_exec_wren", {52'd0, wr_en}, 64'h080);
        check("add_exec_opfa", {60'd0, op_fa}, 64'h1);
        check("add_exec_bus", {32'd0, wr_bus_up}, 64'd5);
        check("add_exec_carry", {63'd0, first_carry}, 64'd0);
        @(negedge clk);
        check("add_resp_k3", {63'd0, resp_valid}, 64'd1);
        wait_idle();

        // Overflow: row0 = 0xFFFFFFFF + 1
        load(0, 32'hFFFF_FFFF);
        load(1, 32'd1);
        expect_resp(1'b0, 1'b1, 1'b1, 0, 32'd0);
        issue(OP_ADD, 1, 0, 1'b0);
        wait_idle();

        // XOR src==dst with response backpressure
        load(2, 32'hA5A5_1234);
        resp_ready = 1'b0;
        expect_resp(1'b0, 1'b0, 1'b1, 2, 32'd0);
        issue(OP_XOR, 2, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("xor_exec_opfa", {60'd0, op_fa}, 64'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_resp_hold", {62'd0, resp_err, resp_ovf}, 64'd0);
            check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("bp_row2", {32'd0, rows[2]}, 64'd0);
        end
        // Offer the next command together with the response handshake.
        expect_resp(1'b0, 1'b0, 1'b1, 0, 32'd5);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_OR; cmd_src = 3; cmd_dst = 0; cmd_cin = 1'b0;
        @(negedge clk);
        check("bp_no_bypass", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check("bp_idle_after_hs", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_read", {52'd0, rd_sel_up}, 64'h008);
        wait_idle();

        // Illegal destination index
        quiet = 1'b1;
        expect_resp(1'b1, 1'b0, 1'b0, 0, 32'd0);
        issue(OP_ADD, 0, 4'd12, 1'b0);
        @(negedge clk);
        check("ill_dst_resp_k1", {63'd0, resp_valid}, 64'd1);
        check("ill_dst_err", {63'd0, resp_err}, 64'd1);
        wait_idle();

        // Illegal opcode 101
        expect_resp(1'b1, 1'b0, 1'b1, 1, 32'd1);
        issue(3'b101, 1, 1, 1'b0);
        @(negedge clk);
        check("ill_op_resp_k1", {63'd0, resp_valid}, 64'd1);
        wait_idle();
        quiet = 1'b0;

        // Subtract: row5 = 10 - 3
        load(4, 32'd3);
        load(5, 32'd10);
`ifdef ROW_SEQ_SUB_EN
        expect_resp(1'b0, 1'b1, 1'b1, 5, 32'd7);
`else
        quiet = 1'b1;
        expect_resp(1'b1, 1'b0, 1'b1, 5, 32'd10);
`endif
        issue(OP_SUB, 4, 5, 1'b0);
        wait_idle();
        quiet = 1'b0;

        // Reset during EXEC
        issue(OP_ADD, 3, 7, 1'b0);
        @(negedge clk);
        check("abort_read_sel", {52'd0, rd_sel_up}, 64'h008);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_exec_wren", {52'd0, wr_en}, 64'h080);
        @(negedge clk);
        check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("abort_outputs", {6'd0, resp_valid, resp_ovf, resp_err, rd_sel_up,
                                wr_sel_up, wr_en, op_fa, first_carry}, 64'd0);
        check("abort_wr_bus", {32'd0, wr_bus_up}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_wren", {52'd0, wr_en}, 64'd0);
            check("abort_no_resp", {63'd0, resp_valid}, 64'd0);
        end

        // Recovery after reset: row3 = 5 & 5
        expect_resp(1'b0, 1'b0, 1'b1, 3, 32'd5);
        issue(OP_AND, 3, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("and_exec_opfa", {60'd0, op_fa}, 64'h2);
        wait_idle();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
